change_dispenser: RTL and testbench

//  Drains a latched balance into physical coins: the outbound counterpart of the

---
 rtl/change_dispenser_pkg.sv | 17 +
 rtl/change_dispenser_coin_select.sv | 29 ++
 rtl/change_dispenser.sv | 111 +++++++++++
 tb/tb_change_dispenser.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: balance width, coin table, FSM states.
package change_dispenser_pkg;

  localparam int kTotalBits = 31;
  localparam int kNumCoins  = 3;

  // Denominations, index 0 = smallest; the picker relies on ascending order.
  localparam logic [kTotalBits-1:0] kCoinValue [kNumCoins] = '{31'd100, 31'd500, 31'd1000};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } disp_state_t;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy picker: largest denomination not exceeding the remaining balance.
module change_dispenser_coin_select
  import change_dispenser_pkg::*;
#(
  parameter int                    TOTAL_BITS = kTotalBits,
  parameter int                    NUM_COINS  = kNumCoins,
  parameter logic [TOTAL_BITS-1:0] COIN_VALUE [NUM_COINS] = kCoinValue
) (
  input  logic [TOTAL_BITS-1:0] i_remaining,
  output logic [NUM_COINS-1:0]  o_onehot,
  output logic [TOTAL_BITS-1:0] o_value,
  output logic                  o_found
);

  // Ascending scan: a later (larger) match overrides, giving priority to the highest coin.
  always_comb begin
    o_onehot = '0;
    o_value  = '0;
    o_found  = 1'b0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (COIN_VALUE[i] <= i_remaining) begin
        o_onehot = NUM_COINS'(1) << i;
        o_value  = COIN_VALUE[i];
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: captures a balance on request and pays it out greedily, one coin
// per valid/ready handshake, reporting each accepted coin as a decrement pulse.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int                    TOTAL_BITS = kTotalBits,
  parameter int                    NUM_COINS  = kNumCoins,
  parameter logic [TOTAL_BITS-1:0] COIN_VALUE [NUM_COINS] = kCoinValue
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [TOTAL_BITS-1:0] total_in,
  output logic                  coin_valid,
  output logic [NUM_COINS-1:0]  coin_sel,
  input  logic                  coin_ready,
  output logic                  dec_valid,
  output logic [TOTAL_BITS-1:0] dec_amount,
  output logic                  busy,
  output logic                  done,
  output logic [TOTAL_BITS-1:0] residue
);

  disp_state_t           r_state;
  logic [TOTAL_BITS-1:0] r_remaining;
  logic [TOTAL_BITS-1:0] r_residue;
  logic [TOTAL_BITS-1:0] r_coin_value;
  logic [NUM_COINS-1:0]  r_coin_sel;
  logic                  r_coin_valid;
  logic                  r_busy;
  logic                  r_done;

  logic [NUM_COINS-1:0]  w_onehot;
  logic [TOTAL_BITS-1:0] w_value;
  logic                  w_found;

  change_dispenser_coin_select #(
    .TOTAL_BITS (TOTAL_BITS),
    .NUM_COINS  (NUM_COINS),
    .COIN_VALUE (COIN_VALUE)
  ) u_coin_select (
    .i_remaining (r_remaining),
    .o_onehot    (w_onehot),
    .o_value     (w_value),
    .o_found     (w_found)
  );

  // Dispense sequencer: capture balance, pick a coin, hold it until accepted, repeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_residue    <= '0;
      r_coin_value <= '0;
      r_coin_sel   <= '0;
      r_coin_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_remaining <= total_in;
            r_busy      <= 1'b1;
            r_state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (w_found) begin
            r_coin_sel   <= w_onehot;
            r_coin_value <= w_value;
            r_coin_valid <= 1'b1;
            r_state      <= ST_PRESENT;
          end else begin
            // Nothing fits: whatever is left cannot be paid out in coins.
            r_residue <= r_remaining;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_PRESENT: begin
          // The picker guaranteed r_coin_value <= r_remaining, so no underflow.
          if (coin_ready) begin
            r_remaining  <= r_remaining - r_coin_value;
            r_coin_sel   <= '0;
            r_coin_valid <= 1'b0;
            r_state      <= ST_SELECT;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign coin_valid = r_coin_valid;
  assign coin_sel   = r_coin_sel;
  assign busy       = r_busy;
  assign done       = r_done;
  assign residue    = r_residue;

  // The decrement is reported in the same cycle the mechanism takes the coin.
  assign dec_valid  = r_coin_valid & coin_ready;
  assign dec_amount = dec_valid ? r_coin_value : '0;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout, residue, stall, busy-start, reset.
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [30:0] total_in;
  logic        coin_valid;
  logic [2:0]  coin_sel;
  logic        coin_ready;
  logic        dec_valid;
  logic [30:0] dec_amount;
  logic        busy;
  logic        done;
  logic [30:0] residue;

  int n_vec = 0;
  int n_err = 0;

  logic [30:0] coin_q [$];
  logic [30:0] dec_sum;
  int          done_cnt;
  int          valid_cnt;

  change_dispenser dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .total_in   (total_in),
    .coin_valid (coin_valid),
    .coin_sel   (coin_sel),
    .coin_ready (coin_ready),
    .dec_valid  (dec_valid),
    .dec_amount (dec_amount),
    .busy       (busy),
    .done       (done),
    .residue    (residue)
  );

  always #5 clk = ~clk;

  // Record every accepted coin and every done pulse as seen at the clock edge.
  always @(posedge clk) begin
    if (dec_valid) begin
      coin_q.push_back(dec_amount);
      dec_sum = dec_sum + dec_amount;
    end
    if (done) done_cnt = done_cnt + 1;
    if (coin_valid) valid_cnt = valid_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    coin_q.delete();
    dec_sum   = '0;
    done_cnt  = 0;
    valid_cnt = 0;
  endtask

  // Pulse start for one edge; afterwards one cycle has elapsed since the capture edge.
  task automatic pulse_start(input logic [30:0] tot);
    total_in = tot;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    total_in = 31'd12345;
  endtask

  // Advance until done is observed; cyc counts edges since the start capture edge.
  task automatic wait_done(inout int cyc, output bit to);
    to = 1'b0;
    while (done !== 1'b1) begin
      if (cyc >= 60) begin
        to = 1'b1;
        return;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; total_in = '0; coin_ready = 1'b0;
    tick(); tick();
    n_vec++; if (coin_valid !== 1'b0) begin n_err++; $display("FAIL reset_coin_valid got %b want 0", coin_valid); end
    n_vec++; if (coin_sel !== 3'b000) begin n_err++; $display("FAIL reset_coin_sel got %b want 000", coin_sel); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    n_vec++; if (dec_valid !== 1'b0 || dec_amount !== 31'd0) begin n_err++; $display("FAIL reset_dec got %b/%0d want 0/0", dec_valid, dec_amount); end
    n_vec++; if (residue !== 31'd0) begin n_err++; $display("FAIL reset_residue got %0d want 0", residue); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_1600();
    int cyc; bit to;
    coin_ready = 1'b1;
    clr_mon();
    pulse_start(31'd1600);
    cyc = 1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL g1600_busy got %b want 1", busy); end
    wait_done(cyc, to);
    n_vec++; if (to) begin n_err++; $display("FAIL g1600_timeout got no done want done"); end
    n_vec++; if (cyc != 8) begin n_err++; $display("FAIL g1600_latency got %0d want 8", cyc); end
    n_vec++; if (coin_q.size() != 3) begin n_err++; $display("FAIL g1600_ncoins got %0d want 3", coin_q.size()); end
    else if (coin_q[0] !== 31'd1000 || coin_q[1] !== 31'd500 || coin_q[2] !== 31'd100) begin
      n_err++; $display("FAIL g1600_order got %0d,%0d,%0d want 1000,500,100", coin_q[0], coin_q[1], coin_q[2]);
    end
    n_vec++; if (dec_sum !== 31'd1600) begin n_err++; $display("FAIL g1600_sum got %0d want 1600", dec_sum); end
    n_vec++; if (residue !== 31'd0) begin n_err++; $display("FAIL g1600_residue got %0d want 0", residue); end
    tick();
    n_vec++; if (done !== 1'b0 || busy !== 1'b0 || done_cnt != 1) begin
      n_err++; $display("FAIL g1600_end got done=%b busy=%b cnt=%0d want 0 0 1", done, busy, done_cnt);
    end
  endtask

  task automatic test_250();
    int cyc; bit to;
    coin_ready = 1'b1;
    clr_mon();
    pulse_start(31'd250);
    cyc = 1;
    wait_done(cyc, to);
    n_vec++; if (to || cyc != 6) begin n_err++; $display("FAIL r250_latency got %0d (to=%b) want 6", cyc, to); end
    n_vec++; if (coin_q.size() != 2 || dec_sum !== 31'd200) begin
      n_err++; $display("FAIL r250_coins got n=%0d sum=%0d want n=2 sum=200", coin_q.size(), dec_sum);
    end
    n_vec++; if (residue !== 31'd50) begin n_err++; $display("FAIL r250_residue got %0d want 50", residue); end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc; bit to;
    coin_ready = 1'b0;
    clr_mon();
    pulse_start(31'd500);
    tick();
    n_vec++; if (coin_valid !== 1'b1 || coin_sel !== 3'b010) begin
      n_err++; $display("FAIL rmid_present got %b/%b want 1/010", coin_valid, coin_sel);
    end
    reset = 1'b1;
    tick();
    n_vec++; if (coin_valid !== 1'b0 || coin_sel !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rmid_outs got v=%b sel=%b busy=%b done=%b want 0 000 0 0", coin_valid, coin_sel, busy, done);
    end
    n_vec++; if (residue !== 31'd0) begin n_err++; $display("FAIL rmid_residue got %0d want 0", residue); end
    coin_ready = 1'b1;
    #1;
    n_vec++; if (dec_valid !== 1'b0 || dec_amount !== 31'd0) begin
      n_err++; $display("FAIL rmid_dec got %b/%0d want 0/0", dec_valid, dec_amount);
    end
    reset = 1'b0;
    tick();
    n_vec++; if (coin_q.size() != 0) begin n_err++; $display("FAIL rmid_nodispense got %0d coins want 0", coin_q.size()); end
    clr_mon();
    pulse_start(31'd250);
    cyc = 1;
    wait_done(cyc, to);
    n_vec++; if (to || cyc != 6 || residue !== 31'd50 || dec_sum !== 31'd200) begin
      n_err++; $display("FAIL rmid_restart got cyc=%0d res=%0d sum=%0d want 6 50 200", cyc, residue, dec_sum);
    end
    tick();
  endtask

  task automatic test_zero();
    int cyc; bit to;
    coin_ready = 1'b1;
    clr_mon();
    pulse_start(31'd0);
    cyc = 1;
    wait_done(cyc, to);
    n_vec++; if (to || cyc != 2) begin n_err++; $display("FAIL zero_latency got %0d (to=%b) want 2", cyc, to); end
    n_vec++; if (valid_cnt != 0) begin n_err++; $display("FAIL zero_novalid got %0d want 0", valid_cnt); end
    n_vec++; if (residue !== 31'd0) begin n_err++; $display("FAIL zero_residue got %0d want 0", residue); end
    tick();
  endtask

  task automatic test_stall();
    int cyc; bit to;
    coin_ready = 1'b0;
    clr_mon();
    pulse_start(31'd500);
    tick();
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (coin_valid !== 1'b1 || coin_sel !== 3'b010 || dec_valid !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d got v=%b sel=%b dec=%b want 1 010 0", k, coin_valid, coin_sel, dec_valid);
      end
      tick();
    end
    coin_ready = 1'b1;
    #1;
    n_vec++; if (dec_valid !== 1'b1 || dec_amount !== 31'd500) begin
      n_err++; $display("FAIL stall_dec got %b/%0d want 1/500", dec_valid, dec_amount);
    end
    cyc = 0;
    wait_done(cyc, to);
    n_vec++; if (to || cyc != 2) begin n_err++; $display("FAIL stall_tail got %0d (to=%b) want 2", cyc, to); end
    n_vec++; if (coin_q.size() != 1 || dec_sum !== 31'd500 || residue !== 31'd0) begin
      n_err++; $display("FAIL stall_total got n=%0d sum=%0d res=%0d want 1 500 0", coin_q.size(), dec_sum, residue);
    end
    tick();
  endtask

  task automatic test_busy_start();
    int cyc; bit to; int vc;
    coin_ready = 1'b1;
    clr_mon();
    pulse_start(31'd1600);
    tick(); tick();
    total_in = 31'd1000;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cyc = 4;
    wait_done(cyc, to);
    n_vec++; if (to || cyc != 8) begin n_err++; $display("FAIL busy_latency got %0d (to=%b) want 8", cyc, to); end
    n_vec++; if (coin_q.size() != 3 || dec_sum !== 31'd1600) begin
      n_err++; $display("FAIL busy_seq got n=%0d sum=%0d want 3 1600", coin_q.size(), dec_sum);
    end
    vc = valid_cnt;
    tick(); tick(); tick(); tick();
    n_vec++; if (busy !== 1'b0 || valid_cnt != vc || done_cnt != 1) begin
      n_err++; $display("FAIL busy_noqueue got busy=%b valid=%0d done=%0d want 0 %0d 1", busy, valid_cnt, done_cnt, vc);
    end
  endtask

  initial begin
    test_reset();
    test_1600();
    test_250();
    test_reset_mid();
    test_zero();
    test_stall();
    test_busy_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
